// File: rtl/wd_cmd_sequencer.sv
// WD1003-style command sequencer: decodes the task-file command, drives seek/media handshakes and paces host DRQ bytes.
// Optional watchdog on every external wait is enabled by defining WD_CMD_TIMEOUT_EN.
module wd_cmd_sequencer #(
    parameter int unsigned SECTOR_BYTES   = 512,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_code,
    input  logic       cmd_valid,
    input  logic [7:0] sector_count,
    input  logic       drive_ready,
    input  logic       host_byte,
    input  logic       seek_done,
    input  logic       seek_err,
    input  logic       xfer_done,
    input  logic       xfer_err,
    output logic       cmd_busy,
    output logic       status_bsy,
    output logic       status_rdy,
    output logic       status_wf,
    output logic       status_sc,
    output logic       status_drq,
    output logic       status_err,
    output logic [7:0] error_code,
    output logic       dec_sector_count,
    output logic       seek_req,
    output logic       seek_restore,
    output logic       xfer_start,
    output logic       xfer_dir
);

    localparam int unsigned BCNT_W = $clog2(SECTOR_BYTES + 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(SECTOR_BYTES - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SEEK      = 4'd1;
    localparam logic [3:0] S_SEEK_WAIT = 4'd2;
    localparam logic [3:0] S_RD_MEDIA  = 4'd3;
    localparam logic [3:0] S_RD_DRQ    = 4'd4;
    localparam logic [3:0] S_WR_DRQ    = 4'd5;
    localparam logic [3:0] S_WR_MEDIA  = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERROR     = 4'd8;

    localparam logic [7:0] E_TK0NF = 8'h02;
    localparam logic [7:0] E_ABRT  = 8'h04;
    localparam logic [7:0] E_IDNF  = 8'h10;
    localparam logic [7:0] E_UNC   = 8'h40;

    logic [3:0]        state_q, state_n;
    logic [8:0]        rem_q, rem_n;
    logic [BCNT_W-1:0] bcnt_q, bcnt_n;
    logic [7:0]        pend_code_q, pend_code_n;
    logic              pend_wf_q, pend_wf_n;
    logic              bsy_n, drq_n, err_n, wf_n, sc_n;
    logic [7:0]        code_n;
    logic              dec_n, seek_req_n, seek_restore_n, xfer_start_n, xfer_dir_n;
    logic              timeout_hit_c;

    logic is_restore_c, is_seek_c, is_read_c, is_write_c;
    assign is_restore_c = (cmd_code[7:4] == 4'h1);
    assign is_seek_c    = (cmd_code[7:4] == 4'h7);
    assign is_read_c    = (cmd_code[7:2] == 6'b001000);
    assign is_write_c   = (cmd_code[7:2] == 6'b001100);

`ifdef WD_CMD_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;
    logic            wd_wait_c;

    assign wd_wait_c = (state_q == S_SEEK_WAIT) || (state_q == S_RD_MEDIA) ||
                       (state_q == S_WR_MEDIA)  || (state_q == S_RD_DRQ)   ||
                       (state_q == S_WR_DRQ);
    assign timeout_hit_c = wd_wait_c && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog restarts on any state change or host activity
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else if (!wd_wait_c || host_byte || (state_n != state_q)) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^32'(TIMEOUT_CYCLES);
    assign timeout_hit_c = 1'b0;
`endif

    // Next state and next registered outputs; pulses default low, levels hold
    always_comb begin
        state_n        = state_q;
        rem_n          = rem_q;
        bcnt_n         = bcnt_q;
        pend_code_n    = pend_code_q;
        pend_wf_n      = pend_wf_q;
        bsy_n          = status_bsy;
        drq_n          = status_drq;
        err_n          = status_err;
        wf_n           = status_wf;
        sc_n           = status_sc;
        code_n         = error_code;
        dec_n          = 1'b0;
        seek_req_n     = 1'b0;
        seek_restore_n = seek_restore;
        xfer_start_n   = 1'b0;
        xfer_dir_n     = xfer_dir;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    bsy_n       = 1'b1;
                    err_n       = 1'b0;
                    code_n      = 8'h00;
                    wf_n        = 1'b0;
                    drq_n       = 1'b0;
                    rem_n       = (sector_count == 8'd0) ? 9'd256 : {1'b0, sector_count};
                    bcnt_n      = '0;
                    pend_code_n = E_ABRT;
                    pend_wf_n   = 1'b0;
                    if (!drive_ready) begin
                        state_n = S_ERROR;
                    end else if (is_restore_c || is_seek_c) begin
                        state_n        = S_SEEK;
                        seek_req_n     = 1'b1;
                        seek_restore_n = is_restore_c;
                        sc_n           = 1'b0;
                        pend_code_n    = is_restore_c ? E_TK0NF : E_IDNF;
                    end else if (is_read_c) begin
                        state_n      = S_RD_MEDIA;
                        xfer_start_n = 1'b1;
                        xfer_dir_n   = 1'b0;
                        pend_code_n  = E_UNC;
                    end else if (is_write_c) begin
                        state_n     = S_WR_DRQ;
                        xfer_dir_n  = 1'b1;
                        pend_code_n = E_IDNF;
                        pend_wf_n   = 1'b1;
                    end else begin
                        state_n = S_ERROR;
                    end
                end
            end
            S_SEEK: state_n = S_SEEK_WAIT;
            S_SEEK_WAIT: begin
                if (seek_err) begin
                    state_n = S_ERROR;
                end else if (seek_done) begin
                    sc_n    = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_RD_MEDIA: begin
                if (xfer_err) begin
                    state_n = S_ERROR;
                end else if (xfer_done) begin
                    state_n = S_RD_DRQ;
                    bsy_n   = 1'b0;
                    drq_n   = 1'b1;
                    bcnt_n  = '0;
                end
            end
            S_RD_DRQ: begin
                if (cmd_valid) begin
                    state_n     = S_ERROR;
                    pend_code_n = E_ABRT;
                    pend_wf_n   = 1'b0;
                    drq_n       = 1'b0;
                end else if (host_byte) begin
                    if (bcnt_q == BCNT_LAST) begin
                        dec_n  = 1'b1;
                        rem_n  = rem_q - 9'd1;
                        bcnt_n = '0;
                        drq_n  = 1'b0;
                        if (rem_q == 9'd1) begin
                            state_n = S_DONE;
                        end else begin
                            state_n      = S_RD_MEDIA;
                            bsy_n        = 1'b1;
                            xfer_start_n = 1'b1;
                            xfer_dir_n   = 1'b0;
                        end
                    end else begin
                        bcnt_n = bcnt_q + BCNT_W'(1);
                    end
                end
            end
            S_WR_DRQ: begin
                bsy_n = 1'b0;
                drq_n = 1'b1;
                if (cmd_valid) begin
                    state_n     = S_ERROR;
                    pend_code_n = E_ABRT;
                    pend_wf_n   = 1'b0;
                    drq_n       = 1'b0;
                end else if (host_byte) begin
                    if (bcnt_q == BCNT_LAST) begin
                        state_n      = S_WR_MEDIA;
                        bcnt_n       = '0;
                        bsy_n        = 1'b1;
                        drq_n        = 1'b0;
                        xfer_start_n = 1'b1;
                        xfer_dir_n   = 1'b1;
                    end else begin
                        bcnt_n = bcnt_q + BCNT_W'(1);
                    end
                end
            end
            S_WR_MEDIA: begin
                if (xfer_err) begin
                    state_n = S_ERROR;
                end else if (xfer_done) begin
                    dec_n = 1'b1;
                    rem_n = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_WR_DRQ;
                        bsy_n   = 1'b0;
                        drq_n   = 1'b1;
                        bcnt_n  = '0;
                    end
                end
            end
            S_DONE: begin
                bsy_n   = 1'b0;
                drq_n   = 1'b0;
                state_n = S_IDLE;
            end
            S_ERROR: begin
                bsy_n   = 1'b0;
                drq_n   = 1'b0;
                err_n   = 1'b1;
                code_n  = pend_code_q;
                wf_n    = pend_wf_q;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Watchdog only fires while a wait state is otherwise holding
        if (timeout_hit_c && (state_n == state_q)) begin
            state_n     = S_ERROR;
            pend_code_n = E_ABRT;
            pend_wf_n   = 1'b0;
            drq_n       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            rem_q            <= '0;
            bcnt_q           <= '0;
            pend_code_q      <= 8'h00;
            pend_wf_q        <= 1'b0;
            cmd_busy         <= 1'b0;
            status_bsy       <= 1'b0;
            status_rdy       <= 1'b0;
            status_wf        <= 1'b0;
            status_sc        <= 1'b1;
            status_drq       <= 1'b0;
            status_err       <= 1'b0;
            error_code       <= 8'h00;
            dec_sector_count <= 1'b0;
            seek_req         <= 1'b0;
            seek_restore     <= 1'b0;
            xfer_start       <= 1'b0;
            xfer_dir         <= 1'b0;
        end else begin
            state_q          <= state_n;
            rem_q            <= rem_n;
            bcnt_q           <= bcnt_n;
            pend_code_q      <= pend_code_n;
            pend_wf_q        <= pend_wf_n;
            cmd_busy         <= (state_n != S_IDLE);
            status_bsy       <= bsy_n;
            status_rdy       <= drive_ready;
            status_wf        <= wf_n;
            status_sc        <= sc_n;
            status_drq       <= drq_n;
            status_err       <= err_n;
            error_code       <= code_n;
            dec_sector_count <= dec_n;
            seek_req         <= seek_req_n;
            seek_restore     <= seek_restore_n;
            xfer_start       <= xfer_start_n;
            xfer_dir         <= xfer_dir_n;
        end
    end

endmodule
